char_store_reader: RTL and testbench
====================================

# char_store_reader

Read-back engine for the vowel/consonant character stores. After a password entry session has split input characters into the vowel RAM and the consonant RAM, this block walks both RAMs in order and streams the stored characters out over a valid/ready interface, tagging each with its class. It sits beside the write path and drives the read address of both 64-entry RAMs.

## Interface
- `DEPTH`, 64: entries per RAM; address width is log2(DEPTH) = 6.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: start a read-back. Sampled only in IDLE.
- `vow_count`, in, 7: number of valid vowel entries, 0..64. Values above 64 are clamped to 64 at `start`.
- `cons_count`, in, 7: number of valid consonant entries, 0..64. Values above 64 are clamped to 64.
- `vow_addr`, out, 6: read address to the vowel RAM.
- `vow_r_data`, in, 8: vowel RAM read data, registered, valid one cycle after `vow_addr`.
- `cons_addr`, out, 6: read address to the consonant RAM.
- `cons_r_data`, in, 8: consonant RAM read data, registered, valid one cycle after `cons_addr`.
- `out_data`, out, 8: character being presented.
- `out_is_vowel`, out, 1: 1 if `out_data` came from the vowel RAM.
- `out_valid`, out, 1: `out_data` and `out_is_vowel` are valid.
- `out_ready`, in, 1: consumer accepts. A transfer occurs on a cycle where `out_valid & out_ready`.
- `busy`, out, 1: a read-back is in progress.
- `done`, out, 1: one-cycle pulse when a read-back completes.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, PRESENT, FINISH.
- IDLE:
  - On `start`, latch the clamped counts and set `idx` = 0.
  - Select the first class. Vowels come first by default.
  - If the first class count is 0, skip to the second class. If both counts are 0, go to FINISH.
  - Otherwise go to ISSUE.
- ISSUE: drive `idx` on the selected RAM address, then go to CAPTURE.
- CAPTURE: register the selected RAM's `r_data` into `out_data`, set `out_is_vowel`, then go to PRESENT.
- PRESENT:
  - `out_valid` = 1. `out_data` and `out_is_vowel` stay stable until transfer.
  - On transfer, increment `idx`.
  - If `idx` + 1 < the current count, go to ISSUE.
  - Otherwise, if the other class is not yet done and its count is nonzero, switch class, set `idx` = 0, and go to ISSUE.
  - Otherwise go to FINISH.
- FINISH: `done` = 1 for one cycle, then go to IDLE.
- `busy` = 1 in every state except IDLE.
- `start` is ignored when not in IDLE. The latched counts do not change during a read-back.
- `idx` is 7 bits internally. The address output is `idx[5:0]`, and it never wraps because `idx` stays below the count, which is at most 64.
- An address output not in use holds its last value.

## Timing
- Reset values: `vow_addr` = 0, `cons_addr` = 0, `out_data` = 0x00, `out_is_vowel` = 0, `out_valid` = 0, `busy` = 0, `done` = 0, state IDLE, `idx` = 0.
- `start` at cycle T gives ISSUE at T+1, CAPTURE at T+2, and `out_valid` first high at T+3.
- Minimum throughput is 1 character per 3 cycles when `out_ready` is held at 1.
- When the class switches, the first character of the new class appears 3 cycles after the last transfer of the old class.
- After the final transfer at cycle T, `done` is high at T+1 and `busy` falls at T+2. `start` is accepted again from T+2.
- If both counts are 0 and `start` is at T, `done` is high at T+1 and no `out_valid` is produced.
- Reset in any state takes effect at the next edge. Any outstanding character is dropped, `out_valid` goes low, and no `done` is produced.

## Configuration
- `CHAR_READER_CONS_FIRST_EN`:
  - Defined: the consonant RAM is read fully before the vowel RAM.
  - Undefined (default): vowels first, then consonants.
  - Timing, empty-class skipping and `done` behaviour are identical in both builds.

## Test plan
- Basic read-back:
  - Stimulus: vowel RAM = {0x61, 0x65}, consonant RAM = {0x62}, counts 2/1, `out_ready` = 1, `start` pulse.
  - Required: transfers 0x61/1, 0x65/1, 0x62/0, spaced 3 cycles apart; `done` 1 cycle after the last transfer.
- Backpressure:
  - Stimulus: same as basic read-back, but `out_ready` held low for 5 cycles while the first character is presented.
  - Required: `out_data` = 0x61 stable, `out_valid` held, no extra transfer, and the order is unchanged.
- Empty and clamped classes:
  - Stimulus: counts 0/3; then counts 0/0.
  - Required: with 0/3, only 3 consonants are output. With 0/0, `done` is high at T+1 and `out_valid` never rises.
  - Stimulus: count 100.
  - Required: exactly 64 transfers, with addresses 0..63.
- Restart guard and mid-run reset:
  - Stimulus: `start` asserted while `busy`.
  - Required: the running read-back is unaffected.
  - Stimulus: `rst` asserted in PRESENT.
  - Required: next cycle `out_valid` = 0, `busy` = 0, and both addresses = 0.
- Configuration build:
  - Stimulus: `CHAR_READER_CONS_FIRST_EN` defined, basic read-back stimulus.
  - Required: order 0x62, 0x61, 0x65.

Source files
------------

// File: rtl/char_store_reader.sv
// Streams the vowel and consonant RAM contents out over valid/ready, one class after the other.
// Define CHAR_READER_CONS_FIRST_EN to read the consonant RAM before the vowel RAM.
module char_store_reader #(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] vow_count,
    input  logic [CW-1:0] cons_count,
    output logic [AW-1:0] vow_addr,
    input  logic [7:0]    vow_r_data,
    output logic [AW-1:0] cons_addr,
    input  logic [7:0]    cons_r_data,
    output logic [7:0]    out_data,
    output logic          out_is_vowel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

`ifdef CHAR_READER_CONS_FIRST_EN
    localparam bit ConsFirst = 1'b1;
`else
    localparam bit ConsFirst = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StIssue, StCapture, StPresent, StFinish} state_e;

    state_e        state;
    logic [CW-1:0] idx;
    logic [CW-1:0] vow_cnt;
    logic [CW-1:0] cons_cnt;
    logic          cur_vowel;
    logic          in_second;

    logic [CW-1:0] vc_clamp;
    logic [CW-1:0] cc_clamp;
    logic          start_vowel;
    logic [CW-1:0] cur_cnt;
    logic [CW-1:0] oth_cnt;
    logic [CW-1:0] idx_next;

    always_comb begin
        vc_clamp = (vow_count > CW'(DEPTH)) ? CW'(DEPTH) : vow_count;
        cc_clamp = (cons_count > CW'(DEPTH)) ? CW'(DEPTH) : cons_count;
        // Class to begin with, skipping an empty first class.
        start_vowel = ConsFirst ? (cc_clamp == '0) : (vc_clamp != '0);
        cur_cnt  = cur_vowel ? vow_cnt : cons_cnt;
        oth_cnt  = cur_vowel ? cons_cnt : vow_cnt;
        idx_next = idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            idx          <= '0;
            vow_cnt      <= '0;
            cons_cnt     <= '0;
            cur_vowel    <= 1'b0;
            in_second    <= 1'b0;
            vow_addr     <= '0;
            cons_addr    <= '0;
            out_data     <= 8'h00;
            out_is_vowel <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        vow_cnt  <= vc_clamp;
                        cons_cnt <= cc_clamp;
                        idx      <= '0;
                        busy     <= 1'b1;
                        if (vc_clamp == '0 && cc_clamp == '0) begin
                            done  <= 1'b1;
                            state <= StFinish;
                        end else begin
                            cur_vowel <= start_vowel;
                            in_second <= (start_vowel == ConsFirst);
                            // Address is set up here so the RAM registers it during ISSUE.
                            if (start_vowel) vow_addr <= '0;
                            else             cons_addr <= '0;
                            state <= StIssue;
                        end
                    end
                end
                StIssue: state <= StCapture;
                StCapture: begin
                    out_data     <= cur_vowel ? vow_r_data : cons_r_data;
                    out_is_vowel <= cur_vowel;
                    out_valid    <= 1'b1;
                    state        <= StPresent;
                end
                StPresent: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx_next < cur_cnt) begin
                            idx <= idx_next;
                            if (cur_vowel) vow_addr <= idx_next[AW-1:0];
                            else           cons_addr <= idx_next[AW-1:0];
                            state <= StIssue;
                        end else if (!in_second && oth_cnt != '0) begin
                            cur_vowel <= !cur_vowel;
                            in_second <= 1'b1;
                            idx       <= '0;
                            if (cur_vowel) cons_addr <= '0;
                            else           vow_addr <= '0;
                            state <= StIssue;
                        end else begin
                            done  <= 1'b1;
                            state <= StFinish;
                        end
                    end
                end
                StFinish: begin
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_char_store_reader.sv
// Scoreboard bench for char_store_reader: RAM models feed the DUT, expected characters are
// queued at start and popped on each observed transfer.
module tb_char_store_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] vow_count;
    logic [6:0] cons_count;
    logic [5:0] vow_addr;
    logic [7:0] vow_r_data;
    logic [5:0] cons_addr;
    logic [7:0] cons_r_data;
    logic [7:0] out_data;
    logic       out_is_vowel;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    char_store_reader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .vow_count    (vow_count),
        .cons_count   (cons_count),
        .vow_addr     (vow_addr),
        .vow_r_data   (vow_r_data),
        .cons_addr    (cons_addr),
        .cons_r_data  (cons_r_data),
        .out_data     (out_data),
        .out_is_vowel (out_is_vowel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    logic [7:0] vmem [64];
    logic [7:0] cmem [64];

    always @(posedge clk) begin
        vow_r_data  <= vmem[vow_addr];
        cons_r_data <= cmem[cons_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    logic [8:0] exp_q[$];
    logic [8:0] e;
    int  run_xfers;
    int  first_xfer_cyc;
    int  last_xfer_cyc;
    int  start_cyc;
    int  done_cyc;
    bit  chk_spacing;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_xfer", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("xfer_data", {24'h0, out_data}, {24'h0, e[7:0]});
                check("xfer_class", {31'h0, out_is_vowel}, {31'h0, e[8]});
            end
            if (run_xfers == 0) first_xfer_cyc = cyc;
            else if (chk_spacing) check("xfer_spacing", cyc - last_xfer_cyc, 3);
            last_xfer_cyc = cyc;
            run_xfers++;
        end
    end

    task automatic push_class(input bit vowel, input int n);
        int m;
        m = (n > 64) ? 64 : n;
        for (int i = 0; i < m; i++) exp_q.push_back({vowel, vowel ? vmem[i] : cmem[i]});
    endtask

    task automatic start_run(input int vc, input int cc);
        run_xfers = 0;
        done_cyc  = -1;
`ifdef CHAR_READER_CONS_FIRST_EN
        push_class(1'b0, cc);
        push_class(1'b1, vc);
`else
        push_class(1'b1, vc);
        push_class(1'b0, cc);
`endif
        @(posedge clk); #1;
        vow_count  = 7'(vc);
        cons_count = 7'(cc);
        start      = 1'b1;
        start_cyc  = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        check("valid_seen", {31'h0, out_valid}, 1);
    endtask

    task automatic finish_run(input int expect_n, input bit chk_first);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 1000);
        check("done_seen", {31'h0, done}, 1);
        done_cyc = cyc;
        if (expect_n > 0) check("done_after_last", done_cyc - last_xfer_cyc, 1);
        else              check("done_empty", done_cyc - start_cyc, 1);
        if (chk_first && expect_n > 0) check("first_latency", first_xfer_cyc - start_cyc, 3);
        check("xfer_count", run_xfers, expect_n);
        check("sb_empty", exp_q.size(), 0);
        @(negedge clk);
        check("done_pulse", {31'h0, done}, 0);
        check("busy_low", {31'h0, busy}, 0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        vow_count  = '0;
        cons_count = '0;
        out_ready  = 1'b1;
        chk_spacing = 1'b1;
        for (int i = 0; i < 64; i++) begin
            vmem[i] = 8'(8'h80 + i);
            cmem[i] = 8'(8'hC0 + i);
        end
        vmem[0] = 8'h61;
        vmem[1] = 8'h65;
        cmem[0] = 8'h62;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vow_addr", {26'h0, vow_addr}, 0);
        check("rst_cons_addr", {26'h0, cons_addr}, 0);
        check("rst_out_data", {24'h0, out_data}, 0);
        check("rst_is_vowel", {31'h0, out_is_vowel}, 0);
        check("rst_valid", {31'h0, out_valid}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        rst = 1'b0;

        // Basic read-back.
        start_run(2, 1);
        finish_run(3, 1'b1);

        // Backpressure on the first character.
        chk_spacing = 1'b0;
        out_ready   = 1'b0;
        start_run(2, 1);
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", {31'h0, out_valid}, 1);
`ifdef CHAR_READER_CONS_FIRST_EN
            check("bp_data", {24'h0, out_data}, 32'h62);
`else
            check("bp_data", {24'h0, out_data}, 32'h61);
`endif
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        finish_run(3, 1'b0);
        chk_spacing = 1'b1;

        // Empty and clamped classes.
        start_run(0, 3);
        finish_run(3, 1'b1);
        start_run(0, 0);
        finish_run(0, 1'b0);
        start_run(100, 0);
        finish_run(64, 1'b1);
        start_run(0, 100);
        finish_run(64, 1'b1);

        // Start while busy must not disturb the running read-back.
        start_run(2, 1);
        wait_valid();
        @(posedge clk); #1;
        vow_count  = 7'd5;
        cons_count = 7'd5;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_run(3, 1'b1);

        // Reset while presenting.
        out_ready = 1'b0;
        start_run(2, 1);
        wait_valid();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mr_valid", {31'h0, out_valid}, 0);
        check("mr_busy", {31'h0, busy}, 0);
        check("mr_done", {31'h0, done}, 0);
        check("mr_vow_addr", {26'h0, vow_addr}, 0);
        check("mr_cons_addr", {26'h0, cons_addr}, 0);
        exp_q.delete();
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("mr_no_done", {31'h0, done}, 0);
        end

        // Reader still works after the reset.
        start_run(2, 1);
        finish_run(3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
